// File: rtl/pattern_bank_if.sv
// pattern_bank_if: bundles the pattern_bank serial, field and buffer-view signals.
//  Parameters match pattern_bank: NUM_BUFS, BUF_BYTES, BYTE_W.
//  Serial port : sclk, sin, ssel, saddr -> sout, load_done
//  View port   : buffer_select -> current_buffer (byte k at [k*BYTE_W +: BYTE_W])
//  Field port  : bufp, fieldp, field_in, field_write, commit -> field_byte, write_err
//  master drives the inputs of pattern_bank; slave is the pattern_bank side.
interface pattern_bank_if #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_BYTES = 32,
  parameter int BYTE_W    = 8
);
  localparam int SEL_W = $clog2(NUM_BUFS);
  localparam int IDX_W = $clog2(BUF_BYTES);
  localparam int N     = BUF_BYTES * BYTE_W;
  logic              sclk, sin, ssel, sout, load_done;
  logic [SEL_W-1:0]  saddr, buffer_select, bufp;
  logic [IDX_W-1:0]  fieldp;
  logic [N-1:0]      current_buffer;
  logic [BYTE_W-1:0] field_in, field_byte;
  logic              field_write, write_err, commit;
  modport master (
    output sclk, sin, ssel, saddr, buffer_select, bufp, fieldp, field_in, field_write, commit,
    input  sout, load_done, current_buffer, field_byte, write_err
  );
  modport slave (
    input  sclk, sin, ssel, saddr, buffer_select, bufp, fieldp, field_in, field_write, commit,
    output sout, load_done, current_buffer, field_byte, write_err
  );
endinterface

// File: rtl/pattern_bank.sv
// pattern_bank: bank of NUM_BUFS pattern buffers (BUF_BYTES x BYTE_W) with serial scan, byte field port and registered view.
//  Ports: clk (rising-edge clock), rst_n (synchronous, active low), bus (pattern_bank_if.slave).
//  sclk/sin are synchronised strobes, never clocks; a shift happens on a synchronised sclk rising edge while ssel=1.
//  Field writes colliding with an enabled serial port on the same buffer are dropped and flagged on write_err.
//  Indices >= NUM_BUFS read as 0 and are never written.
//  Build option PATTERN_BANK_SHADOW_EN: each buffer gets an active copy, loaded from the working copy by commit,
//  and current_buffer shows the active copy. Without it commit is ignored.
module pattern_bank #(
  parameter int NUM_BUFS  = 8,
  parameter int BUF_BYTES = 32,
  parameter int BYTE_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  pattern_bank_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_BUFS);
  localparam int N     = BUF_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [SEL_W:0]   NB   = (SEL_W + 1)'(NUM_BUFS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  typedef logic [BUF_BYTES-1:0][BYTE_W-1:0] buf_t;
  buf_t              work_q [NUM_BUFS];
  buf_t              work_d [NUM_BUFS];
  logic [2:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        sin_sync_q, sin_sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  saddr_prev_q, saddr_prev_d;
  logic              sout_q, sout_d, load_done_q, load_done_d, write_err_q, write_err_d;
  logic [BYTE_W-1:0] field_byte_q, field_byte_d;
  logic [N-1:0]      current_q, current_d, view;
  logic [N-1:0]      flat;
  logic              s_ok, f_ok, b_ok, shift, clear, collide;
  assign s_ok    = {1'b0, bus.saddr} < NB;
  assign f_ok    = {1'b0, bus.bufp} < NB;
  assign b_ok    = {1'b0, bus.buffer_select} < NB;
  // sclk_sync_q[1] is s2, sclk_sync_q[2] is s3
  assign shift   = sclk_sync_q[1] & ~sclk_sync_q[2] & bus.ssel & s_ok;
  assign clear   = ~bus.ssel | (bus.saddr != saddr_prev_q);
  // an enabled serial port owns its buffer, whether or not it shifts this cycle
  assign collide = bus.ssel & (bus.saddr == bus.bufp);
  always_comb begin
    work_d = work_q;
    flat = s_ok ? work_q[bus.saddr] : '0;
    if (shift) work_d[bus.saddr] = {flat[N-2:0], sin_sync_q[1]};
    if (bus.field_write && f_ok && !collide) work_d[bus.bufp][bus.fieldp] = bus.field_in;
  end
`ifdef PATTERN_BANK_SHADOW_EN
  buf_t act_q [NUM_BUFS];
  buf_t act_d [NUM_BUFS];
  // the copy reads work_q, so a same-cycle write lands in the working copy only
  always_comb begin
    act_d = act_q;
    if (bus.commit && f_ok) act_d[bus.bufp] = work_q[bus.bufp];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) act_q <= '{default: '0};
    else act_q <= act_d;
  end
  assign view = b_ok ? act_q[bus.buffer_select] : '0;
`else
  logic unused_commit;
  assign unused_commit = bus.commit;
  assign view = b_ok ? work_q[bus.buffer_select] : '0;
`endif
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], bus.sclk};
    sin_sync_d   = {sin_sync_q[0], bus.sin};
    saddr_prev_d = bus.saddr;
    cnt_d        = clear ? '0 : shift ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    load_done_d  = shift & ~clear & (cnt_q == LAST);
    sout_d       = bus.ssel & s_ok & flat[N-1];
    write_err_d  = bus.field_write & f_ok & collide;
    field_byte_d = f_ok ? work_q[bus.bufp][bus.fieldp] : '0;
    current_d    = view;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q       <= '{default: '0};
      sclk_sync_q  <= '1;
      sin_sync_q   <= '0;
      cnt_q        <= '0;
      saddr_prev_q <= '0;
      sout_q       <= 1'b0;
      load_done_q  <= 1'b0;
      write_err_q  <= 1'b0;
      field_byte_q <= '0;
      current_q    <= '0;
    end else begin
      work_q       <= work_d;
      sclk_sync_q  <= sclk_sync_d;
      sin_sync_q   <= sin_sync_d;
      cnt_q        <= cnt_d;
      saddr_prev_q <= saddr_prev_d;
      sout_q       <= sout_d;
      load_done_q  <= load_done_d;
      write_err_q  <= write_err_d;
      field_byte_q <= field_byte_d;
      current_q    <= current_d;
    end
  end
  assign bus.sout           = sout_q;
  assign bus.load_done      = load_done_q;
  assign bus.write_err      = write_err_q;
  assign bus.field_byte     = field_byte_q;
  assign bus.current_buffer = current_q;
endmodule

// File: tb/tb_pattern_bank.sv
// tb_pattern_bank: directed and randomized checks of pattern_bank against a behavioural model.
module tb_pattern_bank;
  localparam int NB = 6, BB = 32, BW = 8, N = BB * BW;
`ifdef PATTERN_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pattern_bank_if #(.NUM_BUFS(NB), .BUF_BYTES(BB), .BYTE_W(BW)) bus ();
  pattern_bank #(.NUM_BUFS(NB), .BUF_BYTES(BB), .BYTE_W(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [N-1:0]  work [NB];
  logic [N-1:0]  act [NB];
  logic [2:0]    sclk_hist;
  logic [1:0]    sin_hist;
  int            loaded, prev_saddr;
  logic          model_ok = 1'b0;
  logic          e_sout, e_ld, e_err;
  logic [BW-1:0] e_fb;
  logic [N-1:0]  e_cur;
  int            n_vec = 0, n_err = 0, ld_count = 0;
  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // One clock edge of the bank: expected registered outputs from the pre-edge state, then state updates.
  task automatic model_step();
    int sa, bp, bs, fp;
    logic sv, fv, bv, rise, shift, clear;
    if (!rst_n) begin
      foreach (work[i]) begin
        work[i] = '0;
        act[i] = '0;
      end
      sclk_hist = 3'b111;
      sin_hist = 2'b00;
      loaded = 0;
      prev_saddr = 0;
      {e_sout, e_ld, e_err} = 3'b000;
      e_fb = '0;
      e_cur = '0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    sa = int'(bus.saddr);
    bp = int'(bus.bufp);
    bs = int'(bus.buffer_select);
    fp = int'(bus.fieldp);
    sv = sa < NB;
    fv = bp < NB;
    bv = bs < NB;
    rise = sclk_hist[1] && !sclk_hist[2];
    shift = rise && bus.ssel && sv;
    clear = !bus.ssel || sa != prev_saddr;
    e_sout = (bus.ssel && sv) ? work[sa][N-1] : 1'b0;
    e_ld = 1'b0;
    if (clear) loaded = 0;
    else if (shift) begin
      loaded++;
      if (loaded == N) begin
        e_ld = 1'b1;
        loaded = 0;
      end
    end
    e_err = bus.field_write && fv && bus.ssel && sa == bp;
    e_fb = fv ? work[bp][fp*BW +: BW] : '0;
    e_cur = bv ? (SHADOW ? act[bs] : work[bs]) : '0;
    if (SHADOW && bus.commit && fv) act[bp] = work[bp];
    if (shift) work[sa] = {work[sa][N-2:0], sin_hist[1]};
    if (bus.field_write && fv && !(bus.ssel && sa == bp)) work[bp][fp*BW +: BW] = bus.field_in;
    sclk_hist = {sclk_hist[1:0], bus.sclk};
    sin_hist = {sin_hist[0], bus.sin};
    prev_saddr = sa;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    if (model_ok) begin
      chk("sout", N'(bus.sout), N'(e_sout));
      chk("load_done", N'(bus.load_done), N'(e_ld));
      chk("write_err", N'(bus.write_err), N'(e_err));
      chk("field_byte", N'(bus.field_byte), N'(e_fb));
      chk("current_buffer", bus.current_buffer, e_cur);
    end
    if (bus.load_done === 1'b1) ld_count++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic b);
    bus.sin = b;
    bus.sclk = 1'b0;
    cyc(2);
    bus.sclk = 1'b1;
    cyc(2);
  endtask
  task automatic do_commit(input int b);
    bus.bufp = 3'(b);
    bus.commit = 1'b1;
    cyc(1);
    bus.commit = 1'b0;
    cyc(1);
  endtask
  initial begin
    bus.sclk = 1'b1;
    bus.sin = 1'b0;
    bus.ssel = 1'b0;
    bus.saddr = '0;
    bus.buffer_select = '0;
    bus.bufp = '0;
    bus.fieldp = '0;
    bus.field_in = '0;
    bus.field_write = 1'b0;
    bus.commit = 1'b0;
    rst_n = 1'b0;
    cyc(4);
    rst_n = 1'b1;
    cyc(6);
    chk("rst_current", bus.current_buffer, '0);
    chk("rst_field_byte", N'(bus.field_byte), '0);
    chk("rst_sout", N'(bus.sout), '0);
    chk("rst_no_load", N'(ld_count), '0);
    // full load of buffer 3 with 1,0,1,0...
    bus.ssel = 1'b1;
    bus.saddr = 3'd3;
    cyc(1);
    for (int i = 0; i < N; i++) pulse(i % 2 == 0);
    cyc(4);
    chk("load_done_once", N'(ld_count), N'(1));
    do_commit(3);
    bus.buffer_select = 3'd3;
    cyc(1);
    chk("load_pattern", bus.current_buffer, {BB{8'hAA}});
    bus.buffer_select = 3'd2;
    cyc(1);
    chk("buf2_untouched", bus.current_buffer, '0);
    // field write and read-back
    bus.ssel = 1'b0;
    bus.bufp = 3'd5;
    bus.fieldp = 5'd31;
    bus.field_in = 8'hC3;
    bus.field_write = 1'b1;
    cyc(1);
    bus.field_write = 1'b0;
    cyc(1);
    chk("field_rd_c3", N'(bus.field_byte), N'(8'hC3));
    do_commit(5);
    bus.buffer_select = 3'd5;
    cyc(1);
    chk("cur_top_c3", N'(bus.current_buffer[N-1 -: BW]), N'(8'hC3));
    // collision with the enabled serial port
    bus.ssel = 1'b1;
    bus.saddr = 3'd5;
    bus.bufp = 3'd5;
    bus.field_in = 8'h11;
    bus.field_write = 1'b1;
    cyc(1);
    chk("collide_err", N'(bus.write_err), N'(1));
    bus.field_write = 1'b0;
    cyc(1);
    chk("collide_err_1cyc", N'(bus.write_err), '0);
    chk("collide_dropped", N'(bus.field_byte), N'(8'hC3));
    bus.bufp = 3'd4;
    bus.field_in = 8'h77;
    bus.field_write = 1'b1;
    cyc(1);
    chk("other_buf_no_err", N'(bus.write_err), '0);
    bus.field_write = 1'b0;
    cyc(1);
    chk("other_buf_written", N'(bus.field_byte), N'(8'h77));
    // out-of-range buffer index
    bus.ssel = 1'b0;
    bus.bufp = 3'd7;
    bus.field_in = 8'hFF;
    bus.field_write = 1'b1;
    cyc(1);
    chk("oor_no_err", N'(bus.write_err), '0);
    bus.field_write = 1'b0;
    cyc(1);
    chk("oor_read_zero", N'(bus.field_byte), '0);
    // abort a load by dropping ssel, then a full load counted from zero
    bus.ssel = 1'b1;
    bus.saddr = 3'd2;
    cyc(1);
    for (int i = 0; i < 10; i++) pulse(1'($urandom_range(0, 1)));
    bus.ssel = 1'b0;
    cyc(2);
    bus.ssel = 1'b1;
    for (int i = 0; i < N - 10; i++) pulse(1'($urandom_range(0, 1)));
    cyc(4);
    chk("abort_no_load_done", N'(ld_count), N'(1));
    for (int i = 0; i < 10; i++) pulse(1'($urandom_range(0, 1)));
    cyc(4);
    chk("reload_load_done", N'(ld_count), N'(2));
    // working versus active copy
    bus.ssel = 1'b0;
    bus.bufp = 3'd1;
    bus.fieldp = 5'd0;
    bus.field_in = 8'h5A;
    bus.field_write = 1'b1;
    bus.buffer_select = 3'd1;
    cyc(1);
    bus.field_write = 1'b0;
    cyc(1);
`ifdef PATTERN_BANK_SHADOW_EN
    chk("shadow_active_holds", N'(bus.current_buffer[BW-1:0]), '0);
`else
    chk("single_copy_visible", N'(bus.current_buffer[BW-1:0]), N'(8'h5A));
`endif
    bus.commit = 1'b1;
    cyc(1);
    bus.commit = 1'b0;
    cyc(1);
    chk("commit_visible", N'(bus.current_buffer[BW-1:0]), N'(8'h5A));
    // randomized traffic, every cycle checked by the compare process
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.sclk = ~bus.sclk;
      bus.sin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.ssel = ~bus.ssel;
      if ($urandom_range(0, 31) == 0) bus.saddr = 3'($urandom_range(0, 7));
      bus.bufp = ($urandom_range(0, 3) == 0) ? bus.saddr : 3'($urandom_range(0, 7));
      bus.fieldp = 5'($urandom_range(0, BB - 1));
      bus.field_in = 8'($urandom_range(0, 255));
      bus.field_write = 1'($urandom_range(0, 1));
      bus.buffer_select = 3'($urandom_range(0, 7));
      bus.commit = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
